// File: rtl/pwm_output_stage.sv
// ---------------------------------------------------------------------------
// pwm_output_stage : 16-pin off/static/PWM output stage, double-buffered duty
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pwm_output_stage #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_out_lo,
  input  logic [7:0]  en_out_hi,
  input  logic [7:0]  en_pwm_lo,
  input  logic [7:0]  en_pwm_hi,
  input  logic [7:0]  duty,
  output logic [15:0] pwm_out,
  output logic        period_start
);

  localparam int unsigned      PRE_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       duty_act_q, duty_act_d;
  logic [15:0]      pwm_out_q, pwm_out_d;
  logic             period_start_q, period_start_d;

  logic             tick;
  logic             wrap;
  logic             lvl;
  logic [15:0]      en_out;
  logic [15:0]      en_pwm;

  // Outputs are computed from the post-edge counter and shadow so that the
  // first high cycle of a period coincides with the period_start pulse.
  always_comb begin
    tick           = (pre_q == PRE_MAX);
    pre_d          = tick ? '0 : (pre_q + PRE_ONE);
    cnt_d          = tick ? (cnt_q + 8'd1) : cnt_q;
    wrap           = tick && (cnt_q == 8'hFF);
    duty_act_d     = wrap ? duty : duty_act_q;
    lvl            = (duty_act_d == 8'hFF) || (cnt_d < duty_act_d);
    en_out         = {en_out_hi, en_out_lo};
    en_pwm         = {en_pwm_hi, en_pwm_lo};
    pwm_out_d      = en_out & (~en_pwm | {16{lvl}});
    period_start_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q          <= '0;
      cnt_q          <= 8'h00;
      duty_act_q     <= 8'h00;
      pwm_out_q      <= 16'h0000;
      period_start_q <= 1'b0;
    end else begin
      pre_q          <= pre_d;
      cnt_q          <= cnt_d;
      duty_act_q     <= duty_act_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
    end
  end

  assign pwm_out      = pwm_out_q;
  assign period_start = period_start_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_output_stage.sv
// ---------------------------------------------------------------------------
// tb_pwm_output_stage : self-checking bench for pwm_output_stage (CLK_DIV=13)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pwm_output_stage;

  localparam int CLK_DIV = 13;
  localparam int PER     = 256 * CLK_DIV;

  logic        clk;
  logic        rst_n;
  logic [7:0]  en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, duty;
  logic [15:0] pwm_out;
  logic        period_start;

  int n_assert = 0;
  int n_fail   = 0;

  pwm_output_stage #(.CLK_DIV(CLK_DIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_out_lo    (en_out_lo),
    .en_out_hi    (en_out_hi),
    .en_pwm_lo    (en_pwm_lo),
    .en_pwm_hi    (en_pwm_hi),
    .duty         (duty),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Time-based reference: edges since reset release determine cnt and wraps.
  typedef struct packed {
    logic [15:0] pwm;
    logic        ps;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_e;
  int          m_k;
  int          m_c;
  logic [7:0]  m_duty;
  logic        m_lvl;
  logic [15:0] m_eo, m_ep;

  initial begin
    m_k    = 0;
    m_duty = 8'h00;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_k    = 0;
        m_duty = 8'h00;
        m_e    = '0;
      end else begin
        m_k++;
        m_e.ps = ((m_k % PER) == 0);
        if (m_e.ps) m_duty = duty;
        m_c   = (m_k / CLK_DIV) % 256;
        m_lvl = (m_duty == 8'hFF) || (m_c < int'(m_duty));
        m_eo  = {en_out_hi, en_out_lo};
        m_ep  = {en_pwm_hi, en_pwm_lo};
        for (int i = 0; i < 16; i++)
          m_e.pwm[i] = !m_eo[i] ? 1'b0 : (!m_ep[i] ? 1'b1 : m_lvl);
      end
      sb.push_back(m_e);
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (sb.size() == 0) begin
        chk("sb_empty", 0, 1);
      end else begin
        e = sb.pop_front();
        chk("sb_pwm", pwm_out, e.pwm);
        chk("sb_ps", period_start, e.ps);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Samples until the next period_start; counts samples differing from exp.
  task automatic wait_ps(input logic [15:0] exp, output int n, output int bad);
    n   = 0;
    bad = 0;
    do begin
      @(posedge clk);
      #3;
      n++;
      if (!period_start && (pwm_out != exp)) bad++;
    end while (!period_start && n < 5000);
  endtask

  // Called at a period_start sample; measures one whole period.
  task automatic run_period(input logic [15:0] watch, input logic [15:0] stat,
                            input int chg_at, input logic [7:0] chg_duty,
                            output int len, output int hi_run, output int hi_tot,
                            output int bad);
    int ref_pin;
    bit in_run;
    ref_pin = 0;
    for (int i = 15; i >= 0; i--) if (watch[i]) ref_pin = i;
    len = 0; hi_run = 0; hi_tot = 0; bad = 0; in_run = 1'b1;
    do begin
      if (pwm_out[ref_pin]) begin
        hi_tot++;
        if (in_run) hi_run++;
      end else begin
        in_run = 1'b0;
      end
      if (((pwm_out & watch) != 16'h0) && ((pwm_out & watch) != watch)) bad++;
      if ((pwm_out & ~watch) != stat) bad++;
      if (len == chg_at) duty = chg_duty;
      @(posedge clk);
      #3;
      len++;
    end while (!period_start && len < 4000);
  endtask

  task automatic check_period(input string tag, input logic [15:0] watch,
                              input logic [15:0] stat, input int chg_at,
                              input logic [7:0] chg_duty, input int exp_hi);
    int len, hi_run, hi_tot, bad;
    run_period(watch, stat, chg_at, chg_duty, len, hi_run, hi_tot, bad);
    chk({tag, "_len"}, len, PER);
    chk({tag, "_hi_run"}, hi_run, exp_hi);
    chk({tag, "_hi_tot"}, hi_tot, exp_hi);
    chk({tag, "_bad"}, bad, 0);
  endtask

  typedef struct {
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n, bad;

    vecs[0] = '{16'h8001, 16'h0000, 16'h8001};
    vecs[1] = '{16'h0000, 16'h8001, 16'h0000};
    vecs[2] = '{16'hFFFF, 16'h0000, 16'hFFFF};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 16'h0000};
    vecs[4] = '{16'hFFFF, 16'h00FF, 16'hFF00};
    vecs[5] = '{16'h00A5, 16'h0005, 16'h00A0};
    vecs[6] = '{16'hF0F0, 16'h0FF0, 16'hF000};

    rst_n = 1'b0;
    {en_out_hi, en_out_lo} = 16'hFFFF;
    {en_pwm_hi, en_pwm_lo} = 16'hFFFF;
    duty = 8'hFF;
    repeat (3) @(posedge clk);
    #3;
    chk("reset_pwm", pwm_out, 16'h0000);
    chk("reset_ps", period_start, 0);

    @(negedge clk);
    {en_out_hi, en_out_lo} = 16'h0000;
    {en_pwm_hi, en_pwm_lo} = 16'h0000;
    duty  = 8'h00;
    rst_n = 1'b1;

    // First period after reset: duty_act is 0, so PWM-mode pins read low.
    foreach (vecs[i]) begin
      @(negedge clk);
      {en_out_hi, en_out_lo} = vecs[i].en_out;
      {en_pwm_hi, en_pwm_lo} = vecs[i].en_pwm;
      @(posedge clk);
      #3;
      chk($sformatf("vec%0d_pwm", i), pwm_out, vecs[i].exp);
    end

    {en_out_hi, en_out_lo} = 16'h0008;
    {en_pwm_hi, en_pwm_lo} = 16'h0008;
    duty = 8'h80;
    wait_ps(16'h0000, n, bad);
    chk("p0_ps_seen", period_start, 1);
    chk("p0_pin3_low", bad, 0);

    check_period("p1_duty80", 16'h0008, 16'h0000, -1, 8'h00, 1664);
    check_period("p2_duty80", 16'h0008, 16'h0000, 100, 8'h00, 1664);
    check_period("p3_duty00", 16'h0008, 16'h0000, -1, 8'h00, 0);
    check_period("p4_duty00", 16'h0008, 16'h0000, -1, 8'h00, 0);
    check_period("p5_duty00", 16'h0008, 16'h0000, 100, 8'hFF, 0);
    check_period("p6_dutyFF", 16'h0008, 16'h0000, -1, 8'h00, PER);
    check_period("p7_dutyFF", 16'h0008, 16'h0000, 100, 8'h40, PER);
    check_period("p8_duty40", 16'h0008, 16'h0000, 8'h20 * CLK_DIV, 8'hC0, 832);
    check_period("p9_dutyC0", 16'h0008, 16'h0000, -1, 8'h00, 2496);

    {en_out_hi, en_out_lo} = 16'hFFFF;
    {en_pwm_hi, en_pwm_lo} = 16'h00FF;
    duty = 8'h10;
    wait_ps(16'h0000, n, bad);
    check_period("p11_mixed", 16'h00FF, 16'hFF00, -1, 8'h00, 208);

    // Abort mid-period with an async reset, then time the restart.
    repeat (1000) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_pwm", pwm_out, 16'h0000);
    chk("midrst_ps", period_start, 0);
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    wait_ps(16'hFF00, n, bad);
    chk("rel_to_ps_cycles", n, PER);
    chk("rel_first_period", bad, 0);
    check_period("post_rst_mixed", 16'h00FF, 16'hFF00, -1, 8'h00, 208);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
